// File: rtl/vga_overlay_scaler.sv
// rtl/vga_overlay_scaler.sv - framebuffer upscaler with per-frame latched tracking-marker overlay
// Output lags the x/y/sync inputs by RAM_LAT+2 cycles; marker state is re-latched on each vsync fall.
module vga_overlay_scaler #(
  parameter int SRC_W       = 320,
  parameter int SRC_H       = 240,
  parameter int SCALE_SHIFT = 1,
  parameter int ADDR_W      = 17,
  parameter int RAM_LAT     = 2,
  parameter int N_BOX       = 2,
  parameter int THICK       = 3,
  parameter int MIN_HALF    = 5
) (
  input  logic                  vga_clk,
  input  logic                  rst,
  input  logic [9:0]            x_pixel,
  input  logic [9:0]            y_pixel,
  input  logic                  data_enable,
  input  logic                  VGAHS_in,
  input  logic                  VGAVS_in,
  output logic                  fb_rd_en,
  output logic [ADDR_W-1:0]     fb_rd_addr,
  input  logic [15:0]           fb_pixel,
  input  logic [10*N_BOX-1:0]   track_x,
  input  logic [10*N_BOX-1:0]   track_y,
  input  logic [10*N_BOX-1:0]   box_half_w,
  input  logic [10*N_BOX-1:0]   box_half_h,
  input  logic [N_BOX-1:0]      track_valid,
  input  logic [9*N_BOX-1:0]    box_rgb,
  input  logic [1:0]            overlay_mode,
  output logic [2:0]            VGA_R,
  output logic [2:0]            VGA_G,
  output logic [2:0]            VGA_B,
  output logic                  VGAHS,
  output logic                  VGAVS
);

  localparam int PD = RAM_LAT + 1;

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic       blk;
    logic       hit;
    logic       fill;
    logic [8:0] rgb;
  } pipe_t;

  localparam pipe_t PIPE_IDLE = '{de: 1'b0, hs: 1'b1, vs: 1'b1, blk: 1'b0,
                                  hit: 1'b0, fill: 1'b0, rgb: 9'd0};

  logic                   r_vs_prev, r_de_prev, r_armed;
  logic [10*N_BOX-1:0]    r_tx, r_ty, r_hw, r_hh;
  logic [N_BOX-1:0]       r_valid;
  logic [9*N_BOX-1:0]     r_rgb;
  logic [1:0]             r_mode;
  logic [ADDR_W-1:0]      r_row_base, r_col;
  logic [SCALE_SHIFT-1:0] r_sub;
  pipe_t                  r_pipe [PD];

  logic                   w_vs_fall, w_de_rise, w_de_fall, w_oos;
  logic [ADDR_W-1:0]      w_col;
  logic [SCALE_SHIFT-1:0] w_sub;
  logic [11:0]            w_px, w_py;
  logic [N_BOX-1:0]       w_hit, w_edge;
  logic                   w_sel_hit, w_sel_fill;
  logic [8:0]             w_sel_rgb, w_cam, w_out;
  pipe_t                  w_stage, w_tail;
  logic                   w_unused;

  assign w_vs_fall = r_vs_prev & ~VGAVS_in;
  assign w_de_rise = data_enable & ~r_de_prev;
  assign w_de_fall = ~data_enable & r_de_prev;
  assign w_col     = w_de_rise ? '0 : r_col;
  assign w_sub     = w_de_rise ? '0 : r_sub;
  assign w_oos     = (12'(x_pixel >> SCALE_SHIFT) >= 12'(SRC_W)) ||
                     (12'(y_pixel >> SCALE_SHIFT) >= 12'(SRC_H));

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      r_tx <= '0; r_ty <= '0; r_hw <= '0; r_hh <= '0;
      r_valid <= '0; r_rgb <= '0; r_mode <= 2'd0; r_armed <= 1'b0;
    end else if (w_vs_fall) begin
      r_tx <= track_x; r_ty <= track_y; r_hw <= box_half_w; r_hh <= box_half_h;
      r_valid <= track_valid; r_rgb <= box_rgb; r_mode <= overlay_mode; r_armed <= 1'b1;
    end
  end

  // Source column advances once every 2^SCALE_SHIFT active pixels; rows on every 2^S-th line end.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      r_vs_prev  <= 1'b1;
      r_de_prev  <= 1'b0;
      r_row_base <= '0;
      r_col      <= '0;
      r_sub      <= '0;
      fb_rd_en   <= 1'b0;
      fb_rd_addr <= '0;
    end else begin
      r_vs_prev <= VGAVS_in;
      r_de_prev <= data_enable;
      if (w_vs_fall)
        r_row_base <= '0;
      else if (w_de_fall && (&y_pixel[SCALE_SHIFT-1:0]))
        r_row_base <= r_row_base + ADDR_W'(SRC_W);
      if (data_enable) begin
        r_sub      <= w_sub + 1'b1;
        r_col      <= (&w_sub) ? w_col + 1'b1 : w_col;
        fb_rd_addr <= r_row_base + w_col;
      end
      fb_rd_en <= data_enable & ~w_oos;
    end
  end

  assign w_px = {2'b00, x_pixel};
  assign w_py = {2'b00, y_pixel};

  genvar g;
  for (g = 0; g < N_BOX; g++) begin : g_box
    logic [9:0]  w_hw_c, w_hh_c;
    logic [11:0] w_cx, w_cy, w_rw, w_rh, w_dx, w_dy;
    logic        w_area, w_outl, w_cross;

    assign w_hw_c = (r_hw[g*10 +: 10] < 10'(MIN_HALF)) ? 10'(MIN_HALF) : r_hw[g*10 +: 10];
    assign w_hh_c = (r_hh[g*10 +: 10] < 10'(MIN_HALF)) ? 10'(MIN_HALF) : r_hh[g*10 +: 10];
    assign w_cx   = 12'(r_tx[g*10 +: 10]) << SCALE_SHIFT;
    assign w_cy   = 12'(r_ty[g*10 +: 10]) << SCALE_SHIFT;
    assign w_rw   = 12'(w_hw_c) << SCALE_SHIFT;
    assign w_rh   = 12'(w_hh_c) << SCALE_SHIFT;
    assign w_dx   = (w_px >= w_cx) ? w_px - w_cx : w_cx - w_px;
    assign w_dy   = (w_py >= w_cy) ? w_py - w_cy : w_cy - w_py;
    assign w_area = (w_dx <= w_rw) && (w_dy <= w_rh);
    // dist > r-THICK rewritten as dist+THICK > r so small radii cannot underflow.
    assign w_outl = w_area && (({1'b0, w_dx} + 13'(THICK) > {1'b0, w_rw}) ||
                               ({1'b0, w_dy} + 13'(THICK) > {1'b0, w_rh}));
    assign w_cross = w_area && ((w_dx <= 12'(THICK >> 1)) || (w_dy <= 12'(THICK >> 1)));
    assign w_hit[g] = r_valid[g] && (((r_mode == 2'd1) && w_outl) ||
                                     ((r_mode == 2'd2) && w_area) ||
                                     ((r_mode == 2'd3) && w_cross));
    assign w_edge[g] = w_outl;
  end

  always_comb begin
    w_sel_hit  = 1'b0;
    w_sel_fill = 1'b0;
    w_sel_rgb  = '0;
    for (int k = N_BOX - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        w_sel_hit  = 1'b1;
        w_sel_fill = (r_mode == 2'd2) && !w_edge[k];
        w_sel_rgb  = r_rgb[k*9 +: 9];
      end
    end
  end

  assign w_stage = '{de: data_enable, hs: VGAHS_in, vs: VGAVS_in, blk: w_oos | ~r_armed,
                     hit: w_sel_hit, fill: w_sel_fill, rgb: w_sel_rgb};

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      for (int i = 0; i < PD; i++) r_pipe[i] <= PIPE_IDLE;
    end else begin
      r_pipe[0] <= w_stage;
      for (int i = 1; i < PD; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign w_tail   = r_pipe[PD-1];
  assign w_cam    = {fb_pixel[15:13], fb_pixel[10:8], fb_pixel[4:2]};
  assign w_unused = ^{fb_pixel[12:11], fb_pixel[7:5], fb_pixel[1:0]};

  always_comb begin
    w_out = '0;
    if (w_tail.de && !w_tail.blk) begin
      if (w_tail.hit && w_tail.fill)
        w_out = {(w_cam[8:6] >> 1) + (w_tail.rgb[8:6] >> 1),
                 (w_cam[5:3] >> 1) + (w_tail.rgb[5:3] >> 1),
                 (w_cam[2:0] >> 1) + (w_tail.rgb[2:0] >> 1)};
      else if (w_tail.hit)
        w_out = w_tail.rgb;
      else
        w_out = w_cam;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      {VGA_R, VGA_G, VGA_B} <= 9'd0;
      VGAHS <= 1'b1;
      VGAVS <= 1'b1;
    end else begin
      {VGA_R, VGA_G, VGA_B} <= w_out;
      VGAHS <= w_tail.hs;
      VGAVS <= w_tail.vs;
    end
  end

endmodule

// File: tb/tb_vga_overlay_scaler.sv
// tb/tb_vga_overlay_scaler.sv - directed bench for vga_overlay_scaler
// Outputs are logged per cycle at negedge and checked against hand-computed values.
module tb_vga_overlay_scaler;

  localparam int L = 4;

  logic vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic        rst;
  logic [9:0]  x_pixel, y_pixel;
  logic        data_enable, VGAHS_in, VGAVS_in;
  logic        fb_rd_en, fb_rd_en2;
  logic [16:0] fb_rd_addr, fb_rd_addr2;
  logic [15:0] fb_pixel;
  logic [19:0] track_x, track_y, box_half_w, box_half_h;
  logic [1:0]  track_valid;
  logic [17:0] box_rgb;
  logic [1:0]  overlay_mode;
  logic [2:0]  VGA_R, VGA_G, VGA_B, VGA_R2, VGA_G2, VGA_B2;
  logic        VGAHS, VGAVS, VGAHS2, VGAVS2;

  vga_overlay_scaler u_dut (
    .vga_clk(vga_clk), .rst(rst), .x_pixel(x_pixel), .y_pixel(y_pixel),
    .data_enable(data_enable), .VGAHS_in(VGAHS_in), .VGAVS_in(VGAVS_in),
    .fb_rd_en(fb_rd_en), .fb_rd_addr(fb_rd_addr), .fb_pixel(fb_pixel),
    .track_x(track_x), .track_y(track_y), .box_half_w(box_half_w), .box_half_h(box_half_h),
    .track_valid(track_valid), .box_rgb(box_rgb), .overlay_mode(overlay_mode),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGAHS(VGAHS), .VGAVS(VGAVS)
  );

  vga_overlay_scaler #(.SRC_W(256)) u_dut256 (
    .vga_clk(vga_clk), .rst(rst), .x_pixel(x_pixel), .y_pixel(y_pixel),
    .data_enable(data_enable), .VGAHS_in(VGAHS_in), .VGAVS_in(VGAVS_in),
    .fb_rd_en(fb_rd_en2), .fb_rd_addr(fb_rd_addr2), .fb_pixel(fb_pixel),
    .track_x(track_x), .track_y(track_y), .box_half_w(box_half_w), .box_half_h(box_half_h),
    .track_valid(track_valid), .box_rgb(box_rgb), .overlay_mode(overlay_mode),
    .VGA_R(VGA_R2), .VGA_G(VGA_G2), .VGA_B(VGA_B2), .VGAHS(VGAHS2), .VGAVS(VGAVS2)
  );

  // Two-cycle framebuffer; unread cycles return zero so misaligned data shows up black.
  logic [15:0] ram_d1;
  always @(posedge vga_clk) begin
    ram_d1   <= fb_rd_en ? 16'hFFFF : 16'h0000;
    fb_pixel <= ram_d1;
  end

  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  logic [8:0]  lg_rgb  [4096];
  logic [8:0]  lg_rgb2 [4096];
  logic        lg_hs   [4096];
  logic        lg_en   [4096];
  logic        lg_en2  [4096];
  logic [16:0] lg_addr [4096];
  always @(negedge vga_clk) begin
    lg_rgb[cyc % 4096]  <= {VGA_R, VGA_G, VGA_B};
    lg_rgb2[cyc % 4096] <= {VGA_R2, VGA_G2, VGA_B2};
    lg_hs[cyc % 4096]   <= VGAHS;
    lg_en[cyc % 4096]   <= fb_rd_en;
    lg_en2[cyc % 4096]  <= fb_rd_en2;
    lg_addr[cyc % 4096] <= fb_rd_addr;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int x, input int y, input logic de, input logic hs,
                     input logic vs, output int c);
    @(posedge vga_clk);
    #1;
    x_pixel = 10'(x); y_pixel = 10'(y);
    data_enable = de; VGAHS_in = hs; VGAVS_in = vs;
    c = cyc;
  endtask

  task automatic idle(input int n, input int y);
    int c;
    repeat (n) drv(0, y, 1'b0, 1'b1, 1'b1, c);
  endtask

  task automatic vs_fall();
    int c;
    drv(0, 0, 1'b0, 1'b1, 1'b0, c);
    drv(0, 0, 1'b0, 1'b1, 1'b1, c);
  endtask

  task automatic line(input int y, input int x0, input int n, output int cfirst);
    int c;
    for (int i = 0; i < n; i++) begin
      drv(x0 + i, y, 1'b1, 1'b1, 1'b1, c);
      if (i == 0) cfirst = c;
    end
    drv(0, y, 1'b0, 1'b1, 1'b1, c);
  endtask

  function automatic logic [8:0] px_at(input int c);
    return lg_rgb[(c + L) % 4096];
  endfunction

  int c, c_hs, c0, c1, c2, cb, cl, ca, cc, cd, ce, cf;
  int exp01 [6] = '{0, 0, 1, 1, 2, 2};
  int exp2  [3] = '{320, 320, 321};
  logic [8:0] exp_ov [5] = '{9'h1FF, 9'h038, 9'h038, 9'h038, 9'h1FF};

  initial begin
    rst = 1'b1;
    x_pixel = '0; y_pixel = '0; data_enable = 1'b0; VGAHS_in = 1'b1; VGAVS_in = 1'b1;
    track_x = {10'd0, 10'd100}; track_y = {10'd0, 10'd80};
    box_half_w = {10'd0, 10'd20}; box_half_h = {10'd0, 10'd10};
    track_valid = 2'b01; box_rgb = {9'h1C0, 9'h038}; overlay_mode = 2'd1;

    drv(7, 3, 1'b1, 1'b0, 1'b0, c);
    drv(7, 3, 1'b1, 1'b0, 1'b0, c);
    drv(7, 3, 1'b1, 1'b0, 1'b0, c);
    chk("rst_rgb",  {VGA_R, VGA_G, VGA_B}, 9'd0);
    chk("rst_hs",   VGAHS, 1'b1);
    chk("rst_vs",   VGAVS, 1'b1);
    chk("rst_en",   fb_rd_en, 1'b0);
    chk("rst_addr", fb_rd_addr, 17'd0);
    rst = 1'b0;

    idle(3, 0);
    vs_fall();
    idle(2, 0);
    drv(0, 0, 1'b0, 1'b0, 1'b1, c_hs);
    idle(L + 2, 0);
    chk("hs_before_lag", lg_hs[(c_hs + L - 1) % 4096], 1'b1);
    chk("hs_lag4",       lg_hs[(c_hs + L) % 4096], 1'b0);

    line(0, 0, 6, c0);
    line(1, 0, 6, c1);
    line(2, 0, 3, c2);
    line(3, 0, 2, c);
    idle(L + 2, 3);
    for (int i = 0; i < 6; i++) chk($sformatf("addr_y0_x%0d", i), lg_addr[(c0 + i + 1) % 4096], exp01[i]);
    for (int i = 0; i < 6; i++) chk($sformatf("addr_y1_x%0d", i), lg_addr[(c1 + i + 1) % 4096], exp01[i]);
    for (int i = 0; i < 3; i++) chk($sformatf("addr_y2_x%0d", i), lg_addr[(c2 + i + 1) % 4096], exp2[i]);
    chk("en_y0", lg_en[(c0 + 1) % 4096], 1'b1);
    chk("cam_y0_x0", px_at(c0), 9'h1FF);
    chk("cam_y0_x5", px_at(c0 + 5), 9'h1FF);

    for (int y = 4; y < 479; y++) begin
      if (y == 160) line(160, 159, 5, cb);
      else line(y, 0, 1, c);
    end
    line(479, 0, 640, cl);
    idle(L + 2, 479);
    for (int i = 0; i < 5; i++) chk($sformatf("outline_x%0d", 159 + i), px_at(cb + i), exp_ov[i]);
    chk("addr_last",   lg_addr[(cl + 640) % 4096], 17'd76799);
    chk("en_last",     lg_en[(cl + 640) % 4096], 1'b1);
    chk("cam_last",    px_at(cl + 639), 9'h1FF);
    chk("oos_en_512",  lg_en2[(cl + 513) % 4096], 1'b0);
    chk("oos_rgb_512", lg_rgb2[(cl + 512 + L) % 4096], 9'd0);
    chk("src_en_511",  lg_en2[(cl + 512) % 4096], 1'b1);
    chk("src_rgb_511", lg_rgb2[(cl + 511 + L) % 4096], 9'h1FF);

    // Overlapping crosshairs; box1 half 2 is clamped to 5, radius 10 on screen.
    track_x = {10'd110, 10'd100}; track_y = {10'd80, 10'd80};
    box_half_w = {10'd2, 10'd20}; box_half_h = {10'd2, 10'd10};
    track_valid = 2'b11; overlay_mode = 2'd3;
    vs_fall();
    track_valid = 2'b10; track_x = {10'd110, 10'd10};
    drv(220, 160, 1'b1, 1'b1, 1'b1, ca);
    idle(L + 2, 160);
    chk("prio_box0_latched", px_at(ca), 9'h038);

    vs_fall();
    drv(220, 160, 1'b1, 1'b1, 1'b1, cc);
    drv(210, 160, 1'b1, 1'b1, 1'b1, cd);
    drv(209, 160, 1'b1, 1'b1, 1'b1, ce);
    idle(L + 2, 160);
    chk("box1_after_latch", px_at(cc), 9'h1C0);
    chk("box1_min_edge",    px_at(cd), 9'h1C0);
    chk("box1_min_outside", px_at(ce), 9'h1FF);

    track_x = {10'd0, 10'd100}; track_valid = 2'b01;
    box_rgb = {9'h1C0, 9'h000}; overlay_mode = 2'd2;
    vs_fall();
    drv(200, 160, 1'b1, 1'b1, 1'b1, ca);
    drv(161, 160, 1'b1, 1'b1, 1'b1, cc);
    drv(200, 178, 1'b1, 1'b1, 1'b1, cd);
    drv(100, 100, 1'b1, 1'b1, 1'b1, ce);
    idle(L + 2, 160);
    chk("fill_blend",    px_at(ca), 9'h0DB);
    chk("fill_outline",  px_at(cc), 9'h000);
    chk("fill_outline_y", px_at(cd), 9'h000);
    chk("fill_outside",  px_at(ce), 9'h1FF);

    overlay_mode = 2'd0;
    vs_fall();
    drv(161, 160, 1'b1, 1'b1, 1'b1, cf);
    idle(L + 2, 160);
    chk("mode0_cam", px_at(cf), 9'h1FF);

    rst = 1'b1;
    idle(1, 20);
    rst = 1'b0;
    drv(200, 20, 1'b1, 1'b1, 1'b1, ca);
    idle(L + 2, 20);
    chk("rst_midframe_black", px_at(ca), 9'd0);
    vs_fall();
    drv(200, 20, 1'b1, 1'b1, 1'b1, cc);
    idle(L + 2, 20);
    chk("rearm_cam", px_at(cc), 9'h1FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_overlay_scaler.md
Name: vga_overlay_scaler

Overview:
- Parametrised successor to the VGA upscaler/bounding-box painter.
- Sits between vga_control, the camera framebuffer and the VGA pins.
- Upscales a SRC_W x SRC_H RGB565 frame by 2^SCALE_SHIFT using incremental address counters, with no multiplier.
- Overlays N_BOX independently coloured tracking markers, selectable as outline, tinted fill or crosshair.
- Marker geometry and mode are latched once per frame so markers never tear.

Parameters:
- SRC_W, 320, source frame width in pixels
- SRC_H, 240, source frame height in lines
- SCALE_SHIFT, 1, upscale factor is 2^SCALE_SHIFT per axis (1..2)
- ADDR_W, 17, framebuffer address width
- RAM_LAT, 2, framebuffer read latency in cycles (1..4)
- N_BOX, 2, number of overlay markers (1..4)
- THICK, 3, marker line thickness in screen pixels
- MIN_HALF, 5, minimum half-size in source pixels

Ports:
- vga_clk  in  1  pixel clock; single clock domain
- rst  in  1  synchronous, active-high reset
- x_pixel  in  10  screen column, 0..639
- y_pixel  in  10  screen row, 0..479
- data_enable  in  1  active-video qualifier
- VGAHS_in  in  1  hsync from vga_control, active-low
- VGAVS_in  in  1  vsync from vga_control, active-low
- fb_rd_en  out  1  framebuffer read strobe
- fb_rd_addr  out  ADDR_W  framebuffer read address
- fb_pixel  in  16  RGB565 data, valid RAM_LAT cycles after the strobe
- track_x  in  10*N_BOX  per-box source centre X; box k occupies bits [10k+9:10k]
- track_y  in  10*N_BOX  per-box source centre Y
- box_half_w  in  10*N_BOX  per-box source half-width
- box_half_h  in  10*N_BOX  per-box source half-height
- track_valid  in  N_BOX  per-box detection flag
- box_rgb  in  9*N_BOX  per-box colour, R[8:6] G[5:3] B[2:0]
- overlay_mode  in  2  0 = off, 1 = outline, 2 = outline plus tinted fill, 3 = crosshair
- VGA_R  out  3  red output
- VGA_G  out  3  green output
- VGA_B  out  3  blue output
- VGAHS  out  1  delayed hsync
- VGAVS  out  1  delayed vsync

Behaviour:
- Reset, all synchronous on rst=1:
  - VGA_R/G/B=0, VGAHS=1, VGAVS=1, fb_rd_en=0, fb_rd_addr=0.
  - Delay pipes: de=0, hs/vs=1.
  - Shadow registers cleared (valid=0, mode=0). row_base=0, col counters=0.
  - Reset mid-frame: output stays black/idle until the next VGAVS_in falling edge re-latches the shadows. Addressing resynchronises at the next data_enable rise.
- Frame latch: on the cycle VGAVS_in goes 1->0, copy track_*, box_half_*, track_valid, box_rgb and overlay_mode into shadow registers. Inputs changing mid-frame have no visible effect until the next latch.
- Address generation (stage 0):
  - row_base is cleared at the VGAVS_in falling edge.
  - On each data_enable 1->0 transition: if y_pixel[SCALE_SHIFT-1:0] is all ones, row_base += SRC_W.
  - Per active pixel, fb_rd_addr = row_base + src_col. src_col resets to 0 on the data_enable rise and increments after every 2^SCALE_SHIFT active pixels.
  - Out-of-source: if (x_pixel>>S) >= SRC_W or (y_pixel>>S) >= SRC_H, then fb_rd_en=0 and the pixel is flagged black. This covers scaled sizes smaller than the screen.
- Latency: every output lags its x/y/sync input by exactly L = RAM_LAT + 2 cycles. The de, hs, vs, out-of-source flag and per-box hit/fill/colour decisions ride an L-1 deep shift pipe so they align with fb_pixel.
- Geometry, per box k, computed from the undelayed x/y and pipelined. Internal width is 12 bits so nothing overflows.
  - centre = track << S.
  - r = (half < MIN_HALF ? MIN_HALF : half) << S.
  - dist = |pix - centre|.
  - area = dist_x <= r_w and dist_y <= r_h.
  - Outline = area and (dist_x > r_w-THICK or dist_y > r_h-THICK). This gives exactly THICK pixels. If r < THICK the whole area is outline.
  - Crosshair = area and (dist_x <= THICK>>1 or dist_y <= THICK>>1).
  - Box draws only if its shadow valid bit is 1.
- Output, registered:
  - de=0 or out-of-source: output 0.
  - Otherwise the lowest-index box with a hit wins.
  - mode 1 or 3: hit pixel = box_rgb.
  - mode 2: outline pixel = box_rgb; interior pixel = (cam>>1)+(box>>1) per 3-bit channel.
  - Otherwise cam = {fb[15:13], fb[10:8], fb[4:2]}.
  - mode 0: always cam.
- Boxes partially off-screen are clipped naturally; centre 0 is legal.

Test Plan:
- Reset/latency: rst for 3 cycles, then drive a 640x480 timing with RAM_LAT=2 -> outputs 0/1/1 during reset; the first VGAHS fall appears exactly 4 cycles after VGAHS_in fall.
- Addressing, S=1, SRC_W=320: rows 0..3, x=0..5 -> addr 0,0,1,1,2,2 on y=0 and 1; 320,320,321 on y=2; last pixel (639,479) -> 76799.
- Outline: box0 at (100,80), half 20x10, valid, mode 1, rgb 0x038 -> screen x=160..162 on y=160 is green; x=163 is camera; x=159 is camera.
- Priority/min-size: box0 and box1 overlapping, box1 half=2 -> box1 radius 10; on overlap box0 colour wins; valid0=0 -> box1 colour shows.
- Frame latch: change track_x mid-frame -> marker unchanged until after the next VGAVS_in fall; mode 2 interior with cam 0x7 and box 0x0 per channel -> 3.
- Out-of-source: SRC_W=256, S=1 -> x>=512 outputs black with fb_rd_en=0.
